// File: rtl/alu_share_ctrl_if.sv
// Bundle of the thread-side request/response lines and the ALU-side issue/completion lines
// seen by the shared-ALU controller.
interface alu_share_ctrl_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 64
);
    logic                      enable;
    logic                      flush;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*8-1:0]      req_op;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        rsp_done;
    logic [DATA_W-1:0]         rsp_res;
    logic [5:0]                rsp_flags;
    logic                      rsp_err;
    logic                      alu_en;
    logic [7:0]                alu_op;
    logic [DATA_W-1:0]         alu_a;
    logic [DATA_W-1:0]         alu_b;
    logic                      alu_valid;
    logic [DATA_W-1:0]         alu_res;
    logic                      alu_done;
    logic [5:0]                alu_flags;
    logic                      busy;

    modport master (
        input  enable, flush, req, req_op, req_a, req_b, req_valid,
        input  alu_res, alu_done, alu_flags,
        output grant, rsp_done, rsp_res, rsp_flags, rsp_err,
        output alu_en, alu_op, alu_a, alu_b, alu_valid, busy
    );

    modport slave (
        output enable, flush, req, req_op, req_a, req_b, req_valid,
        output alu_res, alu_done, alu_flags,
        input  grant, rsp_done, rsp_res, rsp_flags, rsp_err,
        input  alu_en, alu_op, alu_a, alu_b, alu_valid, busy
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one ALU between NUM_REQ threads, with a completion watchdog.
// Interface parameters must match the module parameters.
module alu_share_ctrl #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst,
    alu_share_ctrl_if.master bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  rsp_done_q, rsp_done_d;
    logic [DATA_W-1:0]   rsp_res_q, rsp_res_d;
    logic [5:0]          rsp_flags_q, rsp_flags_d;
    logic                rsp_err_q, rsp_err_d;
    logic                alu_en_q, alu_en_d;
    logic [7:0]          alu_op_q, alu_op_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic                alu_valid_q, alu_valid_d;
    logic                busy_q, busy_d;

    logic                found_s;
    logic [PTR_W-1:0]    win_s;

    // Round-robin pick: first requester after the previous winner.
    always_comb begin
        found_s = 1'b0;
        win_s   = last_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found_s && bus.req[(int'(last_q) + k) % NUM_REQ]) begin
                found_s = 1'b1;
                win_s   = PTR_W'((int'(last_q) + k) % NUM_REQ);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        rsp_done_d  = {NUM_REQ{1'b0}};
        rsp_res_d   = rsp_res_q;
        rsp_flags_d = rsp_flags_q;
        rsp_err_d   = rsp_err_q;
        alu_en_d    = 1'b0;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_valid_d = alu_valid_q;
        busy_d      = busy_q;

        case (state_q)
            S_IDLE: begin
                if (bus.enable && found_s) begin
                    alu_op_d    = bus.req_op[int'(win_s)*8 +: 8];
                    alu_a_d     = bus.req_a[int'(win_s)*DATA_W +: DATA_W];
                    alu_b_d     = bus.req_b[int'(win_s)*DATA_W +: DATA_W];
                    alu_valid_d = bus.req_valid[win_s];
                    grant_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
                    last_d      = win_s;
                    alu_en_d    = 1'b1;
                    state_d     = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.alu_done) begin
                    rsp_res_d   = bus.alu_res;
                    rsp_flags_d = bus.alu_flags;
                    rsp_err_d   = 1'b0;
                    rsp_done_d  = grant_q;
                    state_d     = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // Watchdog expiry: answer the owner with an error and a zeroed result.
                    rsp_res_d   = {DATA_W{1'b0}};
                    rsp_flags_d = 6'd0;
                    rsp_err_d   = 1'b1;
                    rsp_done_d  = grant_q;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                grant_d   = {NUM_REQ{1'b0}};
                rsp_err_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                grant_d = {NUM_REQ{1'b0}};
                state_d = S_IDLE;
            end
        endcase

        // Flush drops any in-flight op without a response.
        if (bus.flush) begin
            state_d     = S_IDLE;
            last_d      = PTR_W'(NUM_REQ - 1);
            cnt_d       = {CNT_W{1'b0}};
            grant_d     = {NUM_REQ{1'b0}};
            rsp_done_d  = {NUM_REQ{1'b0}};
            rsp_res_d   = {DATA_W{1'b0}};
            rsp_flags_d = 6'd0;
            rsp_err_d   = 1'b0;
            alu_en_d    = 1'b0;
            alu_op_d    = 8'd0;
            alu_a_d     = {DATA_W{1'b0}};
            alu_b_d     = {DATA_W{1'b0}};
            alu_valid_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
            busy_d = (state_d != S_IDLE);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_q      <= PTR_W'(NUM_REQ - 1);
            cnt_q       <= {CNT_W{1'b0}};
            grant_q     <= {NUM_REQ{1'b0}};
            rsp_done_q  <= {NUM_REQ{1'b0}};
            rsp_res_q   <= {DATA_W{1'b0}};
            rsp_flags_q <= 6'd0;
            rsp_err_q   <= 1'b0;
            alu_en_q    <= 1'b0;
            alu_op_q    <= 8'd0;
            alu_a_q     <= {DATA_W{1'b0}};
            alu_b_q     <= {DATA_W{1'b0}};
            alu_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            rsp_done_q  <= rsp_done_d;
            rsp_res_q   <= rsp_res_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_err_q   <= rsp_err_d;
            alu_en_q    <= alu_en_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_valid_q <= alu_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.rsp_done  = rsp_done_q;
    assign bus.rsp_res   = rsp_res_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.alu_en    = alu_en_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_valid = alu_valid_q;
    assign bus.busy      = busy_q;
endmodule
